// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the instruction-fetch and load/store masters.
// Data wins arbitration; an in-order owner FIFO routes each response back to its issuer.
//
// state  | meaning
// FREE   | no pending stalled request; data has priority over inst
// LOCK_I | inst request is stalled downstream; grant held on inst
// LOCK_D | data request is stalled downstream; grant held on data
module sram_bus_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int PTR_W       = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        stray_resp
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(OUTSTANDING);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    state_t r_state;
    state_t w_state_nxt;

    logic [OUTSTANDING-1:0] r_fifo;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [PTR_W:0]         r_count;
    logic                   r_stray;

    logic w_lock_i;
    logic w_lock_d;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_empty;
    logic w_pop;
    logic w_fifo_full;
    logic w_push;
    logic w_head_d;

    // A lock only holds while its owner keeps requesting, so a withdrawn
    // request hands the grant to the other master in the same cycle.
    assign w_lock_i = (r_state == LOCK_I) & inst_sram_req;
    assign w_lock_d = (r_state == LOCK_D) & data_sram_req;
    assign w_gnt_d  = w_lock_d | (~w_lock_i & data_sram_req);
    assign w_gnt_i  = w_lock_i | (~w_lock_d & ~data_sram_req & inst_sram_req);

    // A same-cycle pop frees a slot, so a full FIFO does not block that push.
    assign w_empty     = (r_count == '0);
    assign w_pop       = bus_data_ok & ~w_empty;
    assign w_fifo_full = (r_count == FULL_CNT) & ~w_pop;
    assign w_push      = bus_req & bus_addr_ok;
    assign w_head_d    = r_fifo[r_rptr];

    always_comb begin
        bus_req   = (w_gnt_i | w_gnt_d) & ~w_fifo_full;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_wstrb = 4'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (w_gnt_d) begin
            bus_wr    = data_sram_wr;
            bus_size  = data_sram_size;
            bus_wstrb = data_sram_wstrb;
            bus_addr  = data_sram_addr;
            bus_wdata = data_sram_wdata;
        end else if (w_gnt_i) begin
            bus_wr    = inst_sram_wr;
            bus_size  = inst_sram_size;
            bus_wstrb = inst_sram_wstrb;
            bus_addr  = inst_sram_addr;
            bus_wdata = inst_sram_wdata;
        end
    end

    always_comb begin
        w_state_nxt = FREE;
        if (w_push) begin
            w_state_nxt = FREE;
        end else if (w_gnt_d) begin
            w_state_nxt = LOCK_D;
        end else if (w_gnt_i) begin
            w_state_nxt = LOCK_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_stray <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_gnt_d;
                r_wptr         <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end
            if (bus_data_ok && w_empty) begin
                r_stray <= 1'b1;
            end
        end
    end

    assign inst_sram_addr_ok = bus_addr_ok & bus_req & w_gnt_i;
    assign data_sram_addr_ok = bus_addr_ok & bus_req & w_gnt_d;

    assign inst_sram_data_ok = w_pop & ~w_head_d;
    assign data_sram_data_ok = w_pop & w_head_d;
    assign inst_sram_rdata   = (~w_empty & ~w_head_d) ? bus_rdata : 32'd0;
    assign data_sram_rdata   = (~w_empty &  w_head_d) ? bus_rdata : 32'd0;

    assign stray_resp = r_stray;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: arbitration, locking, order FIFO routing,
// full-FIFO bypass, master withdrawal and stray responses.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stray_resp;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] IADDR = 32'h1c00_0000;
    localparam logic [31:0] DADDR = 32'h1c00_0100;

    sram_bus_arbiter #(.OUTSTANDING(2), .PTR_W(1)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stray_resp(stray_resp)
    );

    always #5 clk = ~clk;

    task automatic idle();
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0;
        inst_sram_addr = IADDR; inst_sram_wdata = 32'h0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_wstrb = 4'h0;
        data_sram_addr = DADDR; data_sram_wdata = 32'h0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); end
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0)
            begin errors++; $display("FAIL reset_oks: got %b expected 0000", {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}); end
        checks++; if (stray_resp !== 1'b0) begin errors++; $display("FAIL reset_stray: got %b expected 0", stray_resp); end
        next_cycle();
    endtask

    task automatic test_priority();
        do_reset();
        inst_sram_req = 1; data_sram_req = 1; bus_addr_ok = 1;
        @(negedge clk);
        checks++; if (bus_addr !== DADDR) begin errors++; $display("FAIL prio_addr: got %h expected %h", bus_addr, DADDR); end
        checks++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10)
            begin errors++; $display("FAIL prio_addr_ok: got %b expected 10", {data_sram_addr_ok, inst_sram_addr_ok}); end
        next_cycle();
        data_sram_req = 0;
        @(negedge clk);
        checks++; if (bus_addr !== IADDR || inst_sram_addr_ok !== 1'b1)
            begin errors++; $display("FAIL prio_inst_next: got addr %h ok %b expected %h 1", bus_addr, inst_sram_addr_ok, IADDR); end
        next_cycle();
        idle();
        bus_data_ok = 1; bus_rdata = 32'h0000_aaaa;
        @(negedge clk);
        checks++; if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b10 || data_sram_rdata !== 32'h0000_aaaa || inst_sram_rdata !== 32'h0)
            begin errors++; $display("FAIL prio_resp_d: got ok %b rd %h/%h expected 10 0000aaaa/0", {data_sram_data_ok, inst_sram_data_ok}, data_sram_rdata, inst_sram_rdata); end
        next_cycle();
        bus_rdata = 32'h0000_bbbb;
        @(negedge clk);
        checks++; if ({data_sram_data_ok, inst_sram_data_ok} !== 2'b01 || inst_sram_rdata !== 32'h0000_bbbb)
            begin errors++; $display("FAIL prio_resp_i: got ok %b rd %h expected 01 0000bbbb", {data_sram_data_ok, inst_sram_data_ok}, inst_sram_rdata); end
        next_cycle();
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        inst_sram_req = 1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                data_sram_req = 1; data_sram_wr = 1; data_sram_wstrb = 4'hf; data_sram_wdata = 32'hcafe_f00d;
            end
            @(negedge clk);
            checks++; if (bus_req !== 1'b1 || bus_addr !== IADDR || data_sram_addr_ok !== 1'b0)
                begin errors++; $display("FAIL lock_hold c%0d: got req %b addr %h dok %b expected 1 %h 0", c, bus_req, bus_addr, data_sram_addr_ok, IADDR); end
            next_cycle();
        end
        bus_addr_ok = 1;
        @(negedge clk);
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10 || bus_addr !== IADDR)
            begin errors++; $display("FAIL lock_hs: got %b addr %h expected 10 %h", {inst_sram_addr_ok, data_sram_addr_ok}, bus_addr, IADDR); end
        next_cycle();
        inst_sram_req = 0;
        @(negedge clk);
        checks++; if (bus_addr !== DADDR || data_sram_addr_ok !== 1'b1 || bus_wr !== 1'b1 || bus_wdata !== 32'hcafe_f00d || bus_wstrb !== 4'hf)
            begin errors++; $display("FAIL lock_data: got addr %h ok %b wr %b wd %h st %h expected %h 1 1 cafef00d f", bus_addr, data_sram_addr_ok, bus_wr, bus_wdata, bus_wstrb, DADDR); end
        next_cycle();
        idle();
        bus_data_ok = 1; bus_rdata = 32'h1;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp_i: got %b expected 1", inst_sram_data_ok); end
        next_cycle();
        @(negedge clk);
        checks++; if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp_d: got %b expected 1", data_sram_data_ok); end
        next_cycle();
        idle();
    endtask

    task automatic test_full_pop();
        do_reset();
        data_sram_req = 1; bus_addr_ok = 1;
        for (int c = 0; c < 2; c++) begin
            data_sram_addr = DADDR + 32'(c * 4);
            @(negedge clk);
            checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL full_acc c%0d: got %b expected 1", c, data_sram_addr_ok); end
            next_cycle();
        end
        data_sram_addr = DADDR + 32'h8;
        @(negedge clk);
        checks++; if (bus_req !== 1'b0 || data_sram_addr_ok !== 1'b0)
            begin errors++; $display("FAIL full_block: got req %b ok %b expected 0 0", bus_req, data_sram_addr_ok); end
        next_cycle();
        bus_data_ok = 1; bus_rdata = 32'hdead_beef;
        @(negedge clk);
        checks++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'hdead_beef)
            begin errors++; $display("FAIL full_pop_resp: got ok %b rd %h expected 1 deadbeef", data_sram_data_ok, data_sram_rdata); end
        checks++; if (bus_req !== 1'b1 || data_sram_addr_ok !== 1'b1)
            begin errors++; $display("FAIL full_pop_push: got req %b ok %b expected 1 1", bus_req, data_sram_addr_ok); end
        next_cycle();
        data_sram_req = 0; bus_addr_ok = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (data_sram_data_ok !== 1'b1) begin errors++; $display("FAIL full_drain c%0d: got %b expected 1", c, data_sram_data_ok); end
            next_cycle();
        end
        bus_data_ok = 0;
        @(negedge clk);
        checks++; if (stray_resp !== 1'b0) begin errors++; $display("FAIL full_no_stray: got %b expected 0", stray_resp); end
        next_cycle();
        idle();
    endtask

    task automatic test_interleave();
        logic [31:0] rd [3];
        logic [1:0]  who [3];
        rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
        who[0] = 2'b01; who[1] = 2'b10; who[2] = 2'b01;
        do_reset();
        bus_addr_ok = 1;
        inst_sram_req = 1;
        next_cycle();
        inst_sram_req = 0; data_sram_req = 1;
        next_cycle();
        data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = IADDR + 32'h4;
        bus_data_ok = 1; bus_rdata = rd[0];
        @(negedge clk);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("FAIL ilv_third_acc: got %b expected 1", inst_sram_addr_ok); end
        for (int k = 0; k < 3; k++) begin
            bus_rdata = rd[k];
            if (k > 0) @(negedge clk);
            checks++; if ({data_sram_data_ok, inst_sram_data_ok} !== who[k] ||
                          (who[k] == 2'b01 ? inst_sram_rdata : data_sram_rdata) !== rd[k])
                begin errors++; $display("FAIL ilv_resp%0d: got ok %b rd i=%h d=%h expected %b %h", k, {data_sram_data_ok, inst_sram_data_ok}, inst_sram_rdata, data_sram_rdata, who[k], rd[k]); end
            next_cycle();
            inst_sram_req = 0; bus_addr_ok = 0;
        end
        idle();
    endtask

    task automatic test_withdraw();
        do_reset();
        data_sram_req = 1;
        next_cycle();
        @(negedge clk);
        checks++; if (bus_addr !== DADDR) begin errors++; $display("FAIL wd_lockd: got %h expected %h", bus_addr, DADDR); end
        next_cycle();
        data_sram_req = 0; inst_sram_req = 1;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1 || bus_addr !== IADDR || data_sram_addr_ok !== 1'b0)
            begin errors++; $display("FAIL wd_switch: got req %b addr %h dok %b expected 1 %h 0", bus_req, bus_addr, data_sram_addr_ok, IADDR); end
        next_cycle();
        data_sram_req = 1; bus_addr_ok = 1;
        @(negedge clk);
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10)
            begin errors++; $display("FAIL wd_locki: got %b expected 10", {inst_sram_addr_ok, data_sram_addr_ok}); end
        next_cycle();
        idle();
        bus_data_ok = 1; bus_rdata = 32'h77;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h77)
            begin errors++; $display("FAIL wd_resp: got %b %h expected 1 00000077", inst_sram_data_ok, inst_sram_rdata); end
        next_cycle();
        idle();
    endtask

    task automatic test_stray();
        do_reset();
        inst_sram_req = 1; bus_addr_ok = 1;
        next_cycle();
        do_reset();
        bus_data_ok = 1; bus_rdata = 32'h55;
        @(negedge clk);
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00 || inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0)
            begin errors++; $display("FAIL stray_route: got ok %b rd %h/%h expected 00 0/0", {inst_sram_data_ok, data_sram_data_ok}, inst_sram_rdata, data_sram_rdata); end
        next_cycle();
        bus_data_ok = 0;
        @(negedge clk);
        checks++; if (stray_resp !== 1'b1) begin errors++; $display("FAIL stray_set: got %b expected 1", stray_resp); end
        next_cycle();
        inst_sram_req = 1; bus_addr_ok = 1;
        next_cycle();
        idle();
        bus_data_ok = 1; bus_rdata = 32'h66;
        @(negedge clk);
        checks++; if (inst_sram_data_ok !== 1'b1 || stray_resp !== 1'b1)
            begin errors++; $display("FAIL stray_no_underflow: got ok %b stray %b expected 1 1", inst_sram_data_ok, stray_resp); end
        next_cycle();
        do_reset();
        @(negedge clk);
        checks++; if (stray_resp !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b expected 0", stray_resp); end
        next_cycle();
    endtask

    initial begin
        idle();
        reset = 1;
        next_cycle();
        next_cycle();
        test_reset();
        test_priority();
        test_lock();
        test_full_pop();
        test_interleave();
        test_withdraw();
        test_stray();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
